// File: rtl/branch_resolve_ctrl_pkg.sv
// Purpose: shared opcode/funct3 codes, FSM state type and latched-instruction
//          record for the control-transfer resolution block.
// Ports:   none (package).
package branch_resolve_ctrl_pkg;

  // in_op encoding; 2'b11 is the illegal op and is handled as the default case
  localparam logic [1:0] OP_BR   = 2'b00;
  localparam logic [1:0] OP_JAL  = 2'b01;
  localparam logic [1:0] OP_JALR = 2'b10;

  // Conditional-branch funct3 (instr[14:12]); 010/011 are reserved
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMP  = 2'd1,
    S_RSLT = 2'd2
  } state_e;

  typedef struct packed {
    logic [1:0]  op;
    logic [2:0]  funct3;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic [31:0] rs2;
  } instr_t;

endpackage

// File: rtl/branch_resolve_ctrl_comp.sv
// Purpose: RV32I branch comparator; equality plus signed/unsigned less-than.
// Latency: combinational.  Backpressure: none.
// Ports:   a, b operands; funct = funct3[2:1] (bit1: relational group,
//          bit0: unsigned); br_eq, br_lt results.
module branch_comp (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [1:0]  funct,
  output logic        br_eq,
  output logic        br_lt
);

  logic lt_signed;
  logic lt_unsigned;

  assign lt_signed   = $signed(a) < $signed(b);
  assign lt_unsigned = a < b;

  assign br_eq = (a == b);
  // BrLT only carries meaning for the relational group (funct3[2]=1);
  // BEQ/BNE consume BrEq alone, so it is held low for them.
  assign br_lt = funct[1] & (funct[0] ? lt_unsigned : lt_signed);

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Purpose: resolves BEQ..BGEU/JAL/JALR into one redirect result (taken, target,
//          link, illegal, misalign) per instruction for the PC-select stage.
// Latency: accept at edge N -> out_valid after edge N+2; at most one in flight.
// Backpressure: in_ready only in IDLE; result held stable until out_ready;
//          flush kills the in-flight instruction and beats out_ready.
// Ports:   clk, rst (sync, active-high); in_valid/in_ready + in_op, in_funct3,
//          in_pc, in_imm, in_rs1, in_rs2; flush; out_valid/out_ready + out_taken,
//          out_target, out_link, out_illegal, out_misalign.
// Option:  BRANCH_STATS_EN adds saturating STAT_W-bit counters stat_resolved and
//          stat_taken, counting completed (non-flushed) handshakes.
module branch_resolve_ctrl
  import branch_resolve_ctrl_pkg::*;
`ifdef BRANCH_STATS_EN
  #(parameter int STAT_W = 32)
`endif
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op,
  input  logic [2:0]        in_funct3,
  input  logic [31:0]       in_pc,
  input  logic [31:0]       in_imm,
  input  logic [31:0]       in_rs1,
  input  logic [31:0]       in_rs2,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_taken,
  output logic [31:0]       out_target,
  output logic [31:0]       out_link,
  output logic              out_illegal,
`ifdef BRANCH_STATS_EN
  output logic              out_misalign,
  output logic [STAT_W-1:0] stat_resolved,
  output logic [STAT_W-1:0] stat_taken
`else
  output logic              out_misalign
`endif
);

  state_e      state_q,    state_d;
  instr_t      instr_q,    instr_d;
  logic        br_eq_q,    br_eq_d;
  logic        br_lt_q,    br_lt_d;
  logic        out_valid_q,    out_valid_d;
  logic        out_taken_q,    out_taken_d;
  logic [31:0] out_target_q,   out_target_d;
  logic [31:0] out_link_q,     out_link_d;
  logic        out_illegal_q,  out_illegal_d;
  logic        out_misalign_q, out_misalign_d;

  logic        cmp_eq;
  logic        cmp_lt;

  logic        res_illegal;
  logic        res_cond;
  logic        res_taken;
  logic [31:0] res_target;
  logic [31:0] pc_rel;
  logic [31:0] reg_rel;

  // Shared comparator works on the latched operands during CMP
  branch_comp u_comp (
    .a     (instr_q.rs1),
    .b     (instr_q.rs2),
    .funct (instr_q.funct3[2:1]),
    .br_eq (cmp_eq),
    .br_lt (cmp_lt)
  );

  // Resolution from latched fields and registered comparator flags
  always_comb begin
    res_illegal = 1'b0;
    res_cond    = 1'b0;
    pc_rel      = instr_q.pc + instr_q.imm;
    reg_rel     = instr_q.rs1 + instr_q.imm;
    res_target  = pc_rel;
    case (instr_q.op)
      OP_BR: begin
        case (instr_q.funct3)
          F3_BEQ:           res_cond = br_eq_q;
          F3_BNE:           res_cond = ~br_eq_q;
          F3_BLT, F3_BLTU:  res_cond = br_lt_q;
          F3_BGE, F3_BGEU:  res_cond = ~br_lt_q;
          default:          res_illegal = 1'b1;
        endcase
      end
      OP_JAL: res_cond = 1'b1;
      OP_JALR: begin
        res_cond    = 1'b1;
        res_illegal = (instr_q.funct3 != 3'b000);
        res_target  = {reg_rel[31:1], 1'b0};
      end
      default: res_illegal = 1'b1;
    endcase
    res_taken = res_cond & ~res_illegal;
  end

  always_comb begin
    state_d        = state_q;
    instr_d        = instr_q;
    br_eq_d        = br_eq_q;
    br_lt_d        = br_lt_q;
    out_valid_d    = out_valid_q;
    out_taken_d    = out_taken_q;
    out_target_d   = out_target_q;
    out_link_d     = out_link_q;
    out_illegal_d  = out_illegal_q;
    out_misalign_d = out_misalign_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          instr_d = '{op: in_op, funct3: in_funct3, pc: in_pc,
                      imm: in_imm, rs1: in_rs1, rs2: in_rs2};
          state_d = S_CMP;
        end
      end
      S_CMP: begin
        br_eq_d = cmp_eq;
        br_lt_d = cmp_lt;
        state_d = S_RSLT;
      end
      S_RSLT: begin
        // First RSLT cycle registers the result; from then on it is frozen
        // until the consumer takes it.
        if (!out_valid_q) begin
          out_valid_d    = 1'b1;
          out_taken_d    = res_taken;
          out_target_d   = res_target;
          out_link_d     = instr_q.pc + 32'd4;
          out_illegal_d  = res_illegal;
          out_misalign_d = res_taken & (res_target[1:0] != 2'b00);
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Flush drops a same-cycle accept and discards any in-flight result
    if (flush) begin
      state_d     = S_IDLE;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      instr_q        <= '0;
      br_eq_q        <= 1'b0;
      br_lt_q        <= 1'b0;
      out_valid_q    <= 1'b0;
      out_taken_q    <= 1'b0;
      out_target_q   <= '0;
      out_link_q     <= '0;
      out_illegal_q  <= 1'b0;
      out_misalign_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      instr_q        <= instr_d;
      br_eq_q        <= br_eq_d;
      br_lt_q        <= br_lt_d;
      out_valid_q    <= out_valid_d;
      out_taken_q    <= out_taken_d;
      out_target_q   <= out_target_d;
      out_link_q     <= out_link_d;
      out_illegal_q  <= out_illegal_d;
      out_misalign_q <= out_misalign_d;
    end
  end

  assign in_ready     = (state_q == S_IDLE);
  assign out_valid    = out_valid_q;
  assign out_taken    = out_taken_q;
  assign out_target   = out_target_q;
  assign out_link     = out_link_q;
  assign out_illegal  = out_illegal_q;
  assign out_misalign = out_misalign_q;

`ifdef BRANCH_STATS_EN
  logic              hs_done;
  logic [STAT_W-1:0] stat_resolved_q, stat_resolved_d;
  logic [STAT_W-1:0] stat_taken_q,    stat_taken_d;

  // A flushed result never completes, even if out_ready was high
  assign hs_done = out_valid_q & out_ready & ~flush;

  always_comb begin
    stat_resolved_d = stat_resolved_q;
    stat_taken_d    = stat_taken_q;
    if (hs_done && !(&stat_resolved_q))
      stat_resolved_d = stat_resolved_q + 1'b1;
    if (hs_done && out_taken_q && !(&stat_taken_q))
      stat_taken_d = stat_taken_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_resolved_q <= '0;
      stat_taken_q    <= '0;
    end else begin
      stat_resolved_q <= stat_resolved_d;
      stat_taken_q    <= stat_taken_d;
    end
  end

  assign stat_resolved = stat_resolved_q;
  assign stat_taken    = stat_taken_q;
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Bench for branch_resolve_ctrl: directed cases plus randomized traffic,
// checked every cycle against a transaction-level model of the block.
module tb_branch_resolve_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_op = '0;
  logic [2:0]  in_funct3 = '0;
  logic [31:0] in_pc = '0, in_imm = '0, in_rs1 = '0, in_rs2 = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_taken;
  logic [31:0] out_target, out_link;
  logic        out_illegal, out_misalign;
`ifdef BRANCH_STATS_EN
  logic [31:0] stat_resolved, stat_taken;
`endif

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;
  bit rand_mode = 0;

  always #5 clk = ~clk;

  branch_resolve_ctrl dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_funct3(in_funct3), .in_pc(in_pc), .in_imm(in_imm),
    .in_rs1(in_rs1), .in_rs2(in_rs2),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_taken(out_taken), .out_target(out_target), .out_link(out_link),
    .out_illegal(out_illegal),
`ifdef BRANCH_STATS_EN
    .out_misalign(out_misalign),
    .stat_resolved(stat_resolved), .stat_taken(stat_taken)
`else
    .out_misalign(out_misalign)
`endif
  );

  typedef struct packed {
    bit        taken;
    bit [31:0] target;
    bit [31:0] link;
    bit        illegal;
    bit        misalign;
  } res_t;

  // Architectural result of one instruction
  function automatic res_t predict(bit [1:0] op, bit [2:0] f3, bit [31:0] pc,
                                   bit [31:0] imm, bit [31:0] rs1, bit [31:0] rs2);
    res_t r;
    bit   t;
    r.link    = pc + 32'd4;
    r.illegal = (op == 2'd3) || (op == 2'd0 && (f3 == 3'd2 || f3 == 3'd3)) ||
                (op == 2'd2 && f3 != 3'd0);
    t = 1'b1;
    if (op == 2'd0) begin
      if      (f3 == 3'd0) t = (rs1 == rs2);
      else if (f3 == 3'd1) t = (rs1 != rs2);
      else if (f3 == 3'd4) t = ($signed(rs1) <  $signed(rs2));
      else if (f3 == 3'd5) t = ($signed(rs1) >= $signed(rs2));
      else if (f3 == 3'd6) t = (rs1 <  rs2);
      else if (f3 == 3'd7) t = (rs1 >= rs2);
    end
    r.target   = (op == 2'd2) ? ((rs1 + imm) & ~32'h1) : (pc + imm);
    r.taken    = t && !r.illegal;
    r.misalign = r.taken && (r.target[1:0] != 2'b00);
    return r;
  endfunction

  // Transaction model: one instruction in flight, result appears two edges
  // after the accepting edge, leaves on ready unless flushed.
  bit          m_busy = 0;
  bit          m_valid = 0;
  int          cyc = 0;
  int          m_acc_cyc = 0;
  res_t        m_exp;
  bit [31:0]   m_res = 0, m_tk = 0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      m_busy = 0; m_valid = 0; m_res = 0; m_tk = 0;
    end else if (m_busy) begin
      if (flush) begin
        m_busy = 0; m_valid = 0;
      end else if (m_valid && out_ready) begin
        if (m_res != 32'hFFFF_FFFF) m_res = m_res + 1;
        if (m_exp.taken && m_tk != 32'hFFFF_FFFF) m_tk = m_tk + 1;
        m_busy = 0; m_valid = 0;
      end else if (cyc == m_acc_cyc + 2) begin
        m_valid = 1;
      end
    end else if (in_valid && !flush) begin
      m_busy    = 1;
      m_acc_cyc = cyc;
      m_exp     = predict(in_op, in_funct3, in_pc, in_imm, in_rs1, in_rs2);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_cycle();
    if (!chk_en) return;
    chk("in_ready", {31'd0, in_ready}, {31'd0, !m_busy});
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    if (m_valid) begin
      chk("taken",    {31'd0, out_taken},    {31'd0, m_exp.taken});
      chk("link",     out_link,              m_exp.link);
      chk("illegal",  {31'd0, out_illegal},  {31'd0, m_exp.illegal});
      chk("misalign", {31'd0, out_misalign}, {31'd0, m_exp.misalign});
      if (!m_exp.illegal) chk("target", out_target, m_exp.target);
    end
`ifdef BRANCH_STATS_EN
    chk("stat_resolved", stat_resolved, m_res);
    chk("stat_taken",    stat_taken,    m_tk);
`endif
  endtask

  // Advance one cycle; inputs change only on the falling edge
  task automatic tick();
    @(negedge clk);
    compare_cycle();
    if (rand_mode) begin
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 24) == 0);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!in_ready && n < 60) begin tick(); n++; end
    if (!in_ready) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    if (!out_valid) chk("valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic send(input bit [1:0] op, input bit [2:0] f3, input bit [31:0] pc,
                      input bit [31:0] imm, input bit [31:0] rs1, input bit [31:0] rs2);
    wait_idle();
    in_op = op; in_funct3 = f3; in_pc = pc; in_imm = imm; in_rs1 = rs1; in_rs2 = rs2;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Issue, wait for the result, let it hand off, return the observed result
  task automatic run_one(input bit [1:0] op, input bit [2:0] f3, input bit [31:0] pc,
                         input bit [31:0] imm, input bit [31:0] rs1, input bit [31:0] rs2,
                         output res_t r);
    out_ready = 1'b1;
    send(op, f3, pc, imm, rs1, rs2);
    wait_valid();
    r.taken = out_taken; r.target = out_target; r.link = out_link;
    r.illegal = out_illegal; r.misalign = out_misalign;
    tick();
  endtask

  initial begin
    res_t r;
    bit [31:0] hold_tgt;
    bit [1:0]  op;
    bit [2:0]  f3;
    bit [31:0] a, b;

    repeat (2) @(negedge clk);
    chk_en = 1;
    compare_cycle();
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_taken",     {31'd0, out_taken}, 32'd0);
    chk("rst_target",    out_target,         32'd0);
    chk("rst_link",      out_link,           32'd0);
    chk("rst_flags",     {30'd0, out_illegal, out_misalign}, 32'd0);
    rst = 1'b0;

    // Pin the model to hand-computed results
    r = predict(2'd0, 3'd0, 32'h100, 32'h20, 32'd5, 32'd5);
    chk("model_beq", {r.taken, r.target[30:0]}, {1'b1, 31'h120});
    r = predict(2'd0, 3'd4, 0, 0, 32'hFFFF_FFFF, 32'd1);
    chk("model_blt", {31'd0, r.taken}, 32'd1);
    r = predict(2'd0, 3'd6, 0, 0, 32'hFFFF_FFFF, 32'd1);
    chk("model_bltu", {31'd0, r.taken}, 32'd0);
    r = predict(2'd2, 3'd0, 0, 32'h2, 32'h1001, 0);
    chk("model_jalr", {r.misalign, r.target[30:0]}, {1'b1, 31'h1002});

    // 1: BEQ taken, result on the third cycle after accept
    out_ready = 1'b1;
    send(2'd0, 3'd0, 32'h100, 32'h20, 32'd5, 32'd5);
    chk("lat_c1", {31'd0, out_valid}, 32'd0);
    tick();
    chk("lat_c2", {31'd0, out_valid}, 32'd0);
    tick();
    chk("lat_c3", {31'd0, out_valid}, 32'd1);
    chk("beq_target", out_target, 32'h120);
    chk("beq_link",   out_link,   32'h104);
    chk("beq_taken",  {31'd0, out_taken}, 32'd1);
    tick();

    // 2: signed vs unsigned compares
    run_one(2'd0, 3'd4, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'd1, r);
    chk("blt_taken", {31'd0, r.taken}, 32'd1);
    run_one(2'd0, 3'd6, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'd1, r);
    chk("bltu_taken", {31'd0, r.taken}, 32'd0);
    run_one(2'd0, 3'd7, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'd1, r);
    chk("bgeu_taken", {31'd0, r.taken}, 32'd1);

    // 3: JALR misaligned target, reserved funct3
    run_one(2'd2, 3'd0, 32'h300, 32'h2, 32'h1001, 32'd0, r);
    chk("jalr_target",   r.target, 32'h1002);
    chk("jalr_misalign", {31'd0, r.misalign}, 32'd1);
    chk("jalr_taken",    {31'd0, r.taken}, 32'd1);
    run_one(2'd0, 3'd2, 32'h300, 32'h8, 32'd1, 32'd1, r);
    chk("f3_010_illegal", {30'd0, r.illegal, r.taken}, 32'd2);

    // 4: held result under backpressure
    out_ready = 1'b0;
    send(2'd1, 3'd5, 32'h400, 32'h7FC, 32'd0, 32'd0);
    wait_valid();
    hold_tgt = out_target;
    repeat (5) begin
      tick();
      chk("hold_valid",  {31'd0, out_valid}, 32'd1);
      chk("hold_target", out_target, hold_tgt);
      chk("hold_busy",   {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    tick();
    chk("release_idle", {31'd0, in_ready}, 32'd1);

    // 5a: flush in CMP
    send(2'd0, 3'd0, 32'h500, 32'h10, 32'd3, 32'd3);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_cmp_idle", {31'd0, in_ready}, 32'd1);
    repeat (4) begin
      tick();
      chk("flush_cmp_novalid", {31'd0, out_valid}, 32'd0);
    end

    // 5b: flush in RSLT beats out_ready
    out_ready = 1'b0;
    send(2'd1, 3'd0, 32'h600, 32'h10, 32'd0, 32'd0);
    wait_valid();
    out_ready = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_rslt_novalid", {31'd0, out_valid}, 32'd0);
    chk("flush_rslt_idle",    {31'd0, in_ready},  32'd1);

    // 6: reset while in CMP, then statistics
    send(2'd0, 3'd1, 32'h700, 32'h10, 32'd1, 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_outs", {29'd0, out_valid, out_taken, out_illegal}, 32'd0);
    chk("rst_mid_target", out_target | out_link, 32'd0);
    chk("rst_mid_idle", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 3; i++) run_one(2'd0, 3'd0, 32'h800, 32'h10, 32'd9, 32'd9, r);
    for (int i = 0; i < 2; i++) run_one(2'd0, 3'd1, 32'h800, 32'h10, 32'd9, 32'd9, r);
`ifdef BRANCH_STATS_EN
    chk("stat_resolved_5", stat_resolved, 32'd5);
    chk("stat_taken_3",    stat_taken,    32'd3);
`endif

    // Randomized traffic with random backpressure and flushes
    rand_mode = 1;
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: op = 2'd0;
        6, 7:             op = 2'd1;
        8:                op = 2'd2;
        default:          op = 2'd3;
      endcase
      f3 = 3'($urandom_range(0, 7));
      if (op == 2'd2 && $urandom_range(0, 3) != 0) f3 = 3'd0;
      a = $urandom();
      case ($urandom_range(0, 2))
        0:       b = a;
        1:       b = a ^ (32'h1 << $urandom_range(0, 31));
        default: b = $urandom();
      endcase
      send(op, f3, $urandom(), ($urandom_range(0, 1) != 0) ? $urandom() : 32'($urandom_range(0, 64)), a, b);
      repeat ($urandom_range(0, 3)) tick();
    end
    rand_mode = 0;
    flush = 1'b0;
    out_ready = 1'b1;
    repeat (8) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
